fetch_prefetch_queue: RTL and testbench
=======================================

Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues word-addressed requests to instruction memory.
- Buffers returned instructions with their PC+1 values in a small FIFO and presents them to IF/ID under the hazard-unit stall.
- Branch/jump redirects flush the FIFO and discard any in-flight fetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (word address).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-low reset.
stall  input  1  hazard-unit stall; when 1, no instruction is consumed by IF/ID.
redirect  input  1  branch/jump taken; one-cycle pulse.
redirect_pc  input  32  new fetch word address; valid when redirect=1.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  word address of the request.
imem_ack  input  1  memory accepted the request and returns data this cycle.
imem_rdata  input  32  instruction word; valid when imem_req & imem_ack.
if_valid  output  1  FIFO head holds a valid instruction.
if_instr  output  32  FIFO head instruction.
if_pc_plus1  output  32  FIFO head fetch address + 1; feeds the IF/ID alu_data input.
if_pop  output  1  if_valid & ~stall & ~redirect; head consumed this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty (count=0, rd_ptr=wr_ptr=0), state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc_plus1=0, if_pop=0.
  - Reset may assert in any state; any outstanding fetch is abandoned without a discard phase.
- Addressing: PC increments by 1 per instruction (word addressing); 32-bit wrap, 32'hFFFF_FFFF+1=0.
- FIFO storage:
  - Each entry holds {instr, pc+1}. Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - The head is registered storage; there is no bypass from imem_rdata to the if_* outputs.
  - Minimum latency: ack at edge N; if_valid=1 with that entry in the cycle after edge N.
- Space rule: a request is issued only when count - pop_this_cycle < DEPTH, so a push can never overflow.
- FSM states: IDLE, REQ, DISCARD.
  - IDLE: imem_req=0.
    - Go to REQ when space is available and redirect=0.
  - REQ: imem_req=1, imem_addr=fetch_pc, held stable until ack.
    - On ack: push {imem_rdata, fetch_pc+1} and set fetch_pc=fetch_pc+1.
    - After ack, stay in REQ if space remains after this cycle's push and pop; otherwise go to IDLE.
    - With imem_ack tied high, throughput is one instruction per cycle.
  - DISCARD: entered when a redirect occurs while a request is outstanding without ack.
    - imem_req=1, imem_addr held at the old address; wait for ack and drop the data (no push).
    - Then go to REQ if space is available (always true, since the FIFO was flushed), else IDLE.
- Redirect has highest priority after reset:
  - On the redirect edge: FIFO flushed (count=0, pointers=0) and fetch_pc=redirect_pc.
  - In that same cycle if_pop=0, and a simultaneous push is dropped.
  - In REQ with ack in the same cycle: data dropped, next state REQ at redirect_pc (no DISCARD).
  - In REQ without ack: go to DISCARD.
  - In IDLE: go to REQ next cycle.
  - In DISCARD: fetch_pc is updated again; remain in DISCARD.
- Stall: the head is held (no pop). The FIFO keeps filling until full, then imem_req drops.
- Simultaneous push and pop: count unchanged; legal when full (pop frees the slot for the push).
- Empty: if_valid=0 and if_instr/if_pc_plus1 hold their last values (don't-care).

Test Plan:
- Reset then stream:
  - Stimulus: rst low 2 cycles then high, imem_ack=1, imem_rdata=addr^32'hA5A5_0000, stall=0.
  - Required: imem_addr=0,1,2,… on consecutive cycles; if_valid first rises 2 cycles after reset release.
  - Required: if_pc_plus1=1,2,3… with matching if_instr; one pop per cycle.
- Stall fill:
  - Stimulus: stall=1 for 8 cycles while streaming.
  - Required: exactly DEPTH=4 pushes; imem_req=0 once count=4; head stays at pc_plus1=1.
  - Required: on stall release, pops 1,2,3,4 followed by 5 with no gap or duplicate.
- Redirect with an outstanding request:
  - Stimulus: imem_ack delayed 3 cycles; redirect=1, redirect_pc=32'h40 while in REQ at addr 7.
  - Required: FIFO empty next cycle; DISCARD holds addr 7 until ack; data not pushed.
  - Required: next request at 32'h40; first popped pc_plus1=32'h41.
- Redirect with same-cycle ack and pop:
  - Stimulus: redirect=1 on a cycle with imem_ack=1 and if_valid=1, stall=0.
  - Required: if_pop=0, no push; next imem_addr=redirect_pc.
- Mid-operation reset:
  - Stimulus: assert rst=0 asynchronously (between clock edges) while in DISCARD with count=3.
  - Required: immediately imem_req=0, if_valid=0; after release, fetch restarts at RESET_PC.
- PC wrap:
  - Stimulus: redirect_pc=32'hFFFF_FFFF.
  - Required: fetched addresses FFFF_FFFF then 0000_0000; if_pc_plus1 of the first entry = 0.

Source files
------------

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word-addressed requests
// and buffers {instr, pc+1} pairs in a small FIFO ahead of the IF/ID register.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus1,
    output logic        if_pop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      discard_addr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [31:0]      instr_mem_r [DEPTH];
    logic [31:0]      pcp1_mem_r  [DEPTH];

    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_after_s;
    logic             space_s;

    // Outputs decode directly from registered state; the head is registered storage.
    assign imem_req    = (state_r != ST_IDLE);
    assign imem_addr   = (state_r == ST_DISCARD) ? discard_addr_r : fetch_pc_r;
    assign if_valid    = (count_r != {CNT_W{1'b0}});
    assign if_instr    = instr_mem_r[rd_ptr_r];
    assign if_pc_plus1 = pcp1_mem_r[rd_ptr_r];
    assign if_pop      = pop_s;

    // Push/pop qualification and post-cycle occupancy used by the space rule.
    always_comb begin
        push_s        = (state_r == ST_REQ) && imem_ack && !redirect;
        pop_s         = if_valid && !stall && !redirect;
        count_after_s = count_r;
        if (push_s && !pop_s) begin
            count_after_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_after_s = count_r - CNT_ONE;
        end else begin
            count_after_s = count_r;
        end
        space_s = (count_after_s < CNT_DEPTH);
    end

    // Next-state logic; redirect outranks everything except reset.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (redirect || space_s) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    state_s = imem_ack ? ST_REQ : ST_DISCARD;
                end else if (imem_ack) begin
                    state_s = space_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    state_s = ST_DISCARD;
                end else if (imem_ack) begin
                    state_s = space_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_s = ST_DISCARD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, fetch PC and the address held while draining an abandoned request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            fetch_pc_r     <= RESET_PC;
            discard_addr_r <= RESET_PC;
        end else begin
            state_r <= state_s;
            if (redirect) begin
                fetch_pc_r <= redirect_pc;
            end else if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd1;
            end
            if ((state_r == ST_REQ) && redirect && !imem_ack) begin
                discard_addr_r <= fetch_pc_r;
            end
        end
    end

    // FIFO pointers, occupancy and storage; a redirect flushes in one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_r[i] <= 32'h0000_0000;
                pcp1_mem_r[i]  <= 32'h0000_0000;
            end
        end else if (redirect) begin
            count_r  <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            count_r <= count_after_s;
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s) begin
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
                instr_mem_r[wr_ptr_r] <= imem_rdata;
                pcp1_mem_r[wr_ptr_r]  <= fetch_pc_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XMASK    = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus1;
    logic        if_pop;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc_plus1 (if_pc_plus1),
        .if_pop      (if_pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the fetcher is doing, where it fetches next, what it holds.
    typedef enum int {M_IDLE, M_REQ, M_DISC} mode_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pcp1;
    } ent_t;

    mode_t       m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_daddr;
    ent_t        q[$];

    int checks   = 0;
    int failures = 0;
    bit rand_data = 1'b0;

    logic        obs_req, obs_valid, obs_pop;
    logic [31:0] obs_addr, obs_pcp1, obs_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = RESET_PC;
        m_daddr = RESET_PC;
        q.delete();
    endtask

    // Asynchronous assertion between edges, immediate output check, release after two edges.
    task automatic do_reset();
        #2 rst = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pop", 32'(if_pop), 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pcp1", if_pc_plus1, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One cycle: drive inputs, compare every output against the model, advance the model.
    task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic ack);
        logic        e_req, e_valid, e_pop, m_push;
        logic [31:0] e_addr, rdata;
        @(negedge clk);
        e_req   = (m_mode != M_IDLE);
        e_addr  = (m_mode == M_DISC) ? m_daddr : m_pc;
        e_valid = (q.size() > 0);
        e_pop   = e_valid && !st && !rd;
        rdata   = rand_data ? $urandom : (e_addr ^ XMASK);
        stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ack; imem_rdata = rdata;
        #1;
        chk("imem_req", 32'(imem_req), 32'(e_req));
        chk("imem_addr", imem_addr, e_addr);
        chk("if_valid", 32'(if_valid), 32'(e_valid));
        chk("if_pop", 32'(if_pop), 32'(e_pop));
        if (e_valid) begin
            chk("if_instr", if_instr, q[0].instr);
            chk("if_pc_plus1", if_pc_plus1, q[0].pcp1);
        end
        obs_req = imem_req; obs_addr = imem_addr; obs_valid = if_valid;
        obs_pop = if_pop; obs_pcp1 = if_pc_plus1; obs_instr = if_instr;
        m_push = (m_mode == M_REQ) && ack && !rd;
        if (rd) begin
            q.delete();
            case (m_mode)
                M_IDLE:  m_mode = M_REQ;
                M_REQ:   begin
                    if (!ack) begin
                        m_daddr = m_pc;
                        m_mode  = M_DISC;
                    end
                end
                default: m_mode = M_DISC;
            endcase
            m_pc = rpc;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (m_push) begin
                q.push_back('{rdata, m_pc + 32'd1});
                m_pc = m_pc + 32'd1;
            end
            if (m_mode == M_IDLE || (ack && m_mode != M_IDLE))
                m_mode = (q.size() < DEPTH) ? M_REQ : M_IDLE;
        end
        chk("fifo_bound", 32'(q.size() <= DEPTH), 32'd1);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pushes;
        int popped[$];
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        model_reset();

        // Reset then stream: addresses 0,1,2..., valid two cycles after release.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 0) chk("stream_valid0", 32'(obs_valid), 32'd0);
            if (k == 1) begin
                chk("stream_valid1", 32'(obs_valid), 32'd0);
                chk("stream_addr1", obs_addr, 32'd0);
            end
            if (k >= 2) begin
                chk("stream_addr", obs_addr, 32'(k - 1));
                chk("stream_pcp1", obs_pcp1, 32'(k - 1));
                chk("stream_instr", obs_instr, 32'(k - 2) ^ XMASK);
                chk("stream_pop", 32'(obs_pop), 32'd1);
            end
        end

        // Stall fill: exactly DEPTH pushes, head pinned at 1, then 1..5 without gap.
        do_reset();
        pushes = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1);
            if (obs_req) pushes++;
        end
        chk("fill_pushes", 32'(pushes), 32'd4);
        chk("fill_req_low", 32'(obs_req), 32'd0);
        chk("fill_head", obs_pcp1, 32'd1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (obs_pop) popped.push_back(int'(obs_pcp1));
        end
        chk("fill_pop_count", 32'(popped.size()), 32'd5);
        for (int k = 0; k < popped.size(); k++) chk("fill_pop_seq", 32'(popped[k]), 32'(k + 1));

        // Redirect while a request at address 7 is outstanding.
        do_reset();
        for (int k = 0; k < 20 && !(m_mode == M_REQ && m_pc == 32'd7); k++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("reach_addr7", 32'(m_mode == M_REQ && m_pc == 32'd7), 32'd1);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        chk("disc_redirect_addr", obs_addr, 32'd7);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'h0, (k == 2));
            chk("disc_hold_addr", obs_addr, 32'd7);
            chk("disc_empty", 32'(obs_valid), 32'd0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("disc_new_addr", obs_addr, 32'h40);
        chk("disc_no_push", 32'(obs_valid), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("disc_first_pcp1", obs_pcp1, 32'h41);

        // Redirect on a cycle with ack and a poppable head.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h123, 1'b1);
        chk("samecyc_valid", 32'(obs_valid), 32'd1);
        chk("samecyc_pop", 32'(obs_pop), 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("samecyc_addr", obs_addr, 32'h123);
        chk("samecyc_nopush", 32'(obs_valid), 32'd0);

        // PC wrap through FFFF_FFFF.
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr0", obs_addr, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_addr1", obs_addr, 32'h0000_0000);
        chk("wrap_pcp1", obs_pcp1, 32'h0000_0000);

        // Reset in DISCARD, then restart at RESET_PC.
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h80, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_reset_disc", 32'(m_mode == M_DISC), 32'd1);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("restart_addr_a", obs_addr, RESET_PC);

        // Reset with three entries buffered and a request outstanding.
        for (int k = 0; k < 10 && q.size() != 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("reach_count3", 32'(q.size()), 32'd3);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("restart_addr_b", obs_addr, RESET_PC);

        // Randomized traffic against the model.
        rand_data = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom,
                 $urandom_range(0, 9) < 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
